// File: rtl/arf028b032e2r2w0cbbehraa4acw_rd_port_ctl_if.sv
// Handshake/bus bundle between a read requester, one register-file array
// read port, the array write port snoop and the response consumer.
// slave  : the read-port controller's view.
// master : the surrounding environment's view.
interface arf028b032e2r2w0cbbehraa4acw_rd_port_ctl_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
);
  logic              req_vld;
  logic [AWIDTH-1:0] req_addr;
  logic              req_rdy;

  logic              arr_rden;
  logic [AWIDTH-1:0] arr_addr;
  logic [DWIDTH-1:0] arr_rdata;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;

  logic              rsp_vld;
  logic [DWIDTH-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_rdy;

  modport slave (
    input  req_vld, req_addr, arr_rdata, wr_en, wr_addr, wr_data, rsp_rdy,
    output req_rdy, arr_rden, arr_addr, rsp_vld, rsp_data, rsp_err
  );

  modport master (
    output req_vld, req_addr, arr_rdata, wr_en, wr_addr, wr_data, rsp_rdy,
    input  req_rdy, arr_rden, arr_addr, rsp_vld, rsp_data, rsp_err
  );
endinterface

// File: rtl/arf028b032e2r2w0cbbehraa4acw_rd_port_ctl.sv
// Read-port controller for the 28 x 32 register-file array.
// Accepts read requests, drives the array read port, captures the array data
// one cycle later and returns responses in order through a 3-entry queue.
// Optional same-cycle write bypass is built when the macro
// ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN is defined; otherwise stage 2
// always returns the array read data.
module arf028b032e2r2w0cbbehraa4acw_rd_port_ctl #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DEPTH  = 28
) (
  input  logic clk,
  input  logic rst,
  arf028b032e2r2w0cbbehraa4acw_rd_port_ctl_if.slave bus
);

  localparam int unsigned QDEPTH = 3;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned OCC_W  = 3;

  typedef struct packed {
    logic              err;
    logic [DWIDTH-1:0] data;
  } rsp_t;

  // Stage 1: request accepted last cycle, array data arrives this cycle
  logic              s1_vld;
  logic              s1_err;
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
  logic              byp_hit;
  logic [DWIDTH-1:0] byp_data;
`endif

  // Output queue
  rsp_t              fifo_mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              in_range_c;
  logic [OCC_W-1:0]  occ_c;
  logic              req_rdy_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic              rsp_vld_c;
  rsp_t              push_ent_c;
  rsp_t              head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance: slots in flight plus queued entries must leave room for one more
  always_comb begin
    in_range_c = (32'(bus.req_addr) < DEPTH);
    occ_c      = OCC_W'(fifo_cnt) + OCC_W'(s1_vld);
    req_rdy_c  = rst & (occ_c < OCC_W'(QDEPTH));
    accept_c   = bus.req_vld & req_rdy_c;
  end

  assign bus.req_rdy  = req_rdy_c;
  assign bus.arr_rden = accept_c & in_range_c;
  assign bus.arr_addr = bus.req_addr;

  // Stage 2: choose the response payload pushed into the queue
  always_comb begin
    push_ent_c = '0;
    push_c     = s1_vld;
    if (s1_err) begin
      push_ent_c.err = 1'b1;
    end
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
    else if (byp_hit) begin
      push_ent_c.data = byp_data;
    end
`endif
    else begin
      push_ent_c.data = bus.arr_rdata;
    end
  end

  // Queue head presentation and pop qualification
  always_comb begin
    rsp_vld_c = (fifo_cnt != '0);
    head_c    = fifo_mem[rd_ptr];
    pop_c     = rsp_vld_c & bus.rsp_rdy;
  end

  assign bus.rsp_vld  = rsp_vld_c;
  assign bus.rsp_data = rsp_vld_c ? head_c.data : '0;
  assign bus.rsp_err  = rsp_vld_c & head_c.err;

  // Stage-1 register, loaded on each accepted request
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_err   <= 1'b0;
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
      byp_hit  <= 1'b0;
      byp_data <= '0;
`endif
    end else begin
      s1_vld <= accept_c;
      if (accept_c) begin
        s1_err   <= ~in_range_c;
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
        // Array read this cycle misses a write committing this cycle
        byp_hit  <= bus.wr_en & (bus.wr_addr == bus.req_addr);
        byp_data <= bus.wr_data;
`endif
      end
    end
  end

  // Output queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push_c) begin
        fifo_mem[wr_ptr] <= push_ent_c;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_arf028b032e2r2w0cbbehraa4acw_rd_port_ctl.sv
// Bench for the register-file read-port controller: behavioural array model,
// queue-based response model, directed scenarios and a randomized phase.
module tb_arf028b032e2r2w0cbbehraa4acw_rd_port_ctl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 28;

  logic clk = 1'b0;
  logic rst = 1'b0;

  arf028b032e2r2w0cbbehraa4acw_rd_port_ctl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  arf028b032e2r2w0cbbehraa4acw_rd_port_ctl #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-file array: registered read, write commits at end of cycle
  logic [DW-1:0] mem [32];
  logic [DW-1:0] pre [32];
  always @(posedge clk) begin
    if (bus.arr_rden) bus.arr_rdata <= mem[bus.arr_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Reference model: every accepted request becomes one queued response,
  // visible two cycles after acceptance, at most three outstanding.
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            ready;
  } exp_t;
  exp_t q[$];
  int   edge_n = 0;
  bit   m_acc;
  bit   m_byp;
  exp_t m_e;

  always @(posedge clk) begin
    m_acc = rst && bus.req_vld && (q.size() < 3);
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
    m_byp = bus.wr_en && (bus.wr_addr == bus.req_addr);
`else
    m_byp = 1'b0;
`endif
    if (!rst) q.delete();
    else if (q.size() > 0 && q[0].ready <= edge_n && bus.rsp_rdy) void'(q.pop_front());
    edge_n++;
    if (m_acc) begin
      m_e.err   = (bus.req_addr >= AW'(DEPTH));
      m_e.data  = m_e.err ? '0 : (m_byp ? bus.wr_data : mem[bus.req_addr]);
      m_e.ready = edge_n + 1;
      q.push_back(m_e);
    end
  end

  // Popped-response log for the literal checks
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            edge_i;
  } log_t;
  log_t log_q[$];

  logic exp_vld;
  logic exp_rdy;

  // Compare DUT against model every cycle, mid-cycle
  always @(negedge clk) begin
    exp_vld = (q.size() > 0) && (q[0].ready <= edge_n);
    exp_rdy = rst && (q.size() < 3);
    chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
    chk("arr_rden", 64'(bus.arr_rden),
        64'(bus.req_vld && exp_rdy && (bus.req_addr < AW'(DEPTH))));
    chk("arr_addr", 64'(bus.arr_addr), 64'(bus.req_addr));
    chk("rsp_vld", 64'(bus.rsp_vld), 64'(exp_vld));
    if (exp_vld) begin
      chk("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
      chk("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
    end
    if (bus.rsp_vld && bus.rsp_rdy) log_q.push_back('{bus.rsp_data, bus.rsp_err, edge_n});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, output logic rden);
    int n = 0;
    bus.req_vld  = 1'b1;
    bus.req_addr = a;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    @(negedge clk);
    while (!bus.req_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_rdy) chk("accept_timeout", 64'(0), 64'(1));
    rden = bus.arr_rden;
    step();
    bus.req_vld = 1'b0;
    bus.wr_en   = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [DW-1:0] d, input logic e,
                            output int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_vld && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rsp_vld) chk({name, "_timeout"}, 64'(0), 64'(1));
    else begin
      chk({name, "_data"}, 64'(bus.rsp_data), 64'(d));
      chk({name, "_err"}, 64'(bus.rsp_err), 64'(e));
    end
    lat = n;
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic rden;
    int   lat;
    int   base;
    int   n;
    logic [DW-1:0] byp_exp;

    bus.req_vld  = 1'b0;
    bus.req_addr = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsp_rdy  = 1'b0;

    // Preload the array through its write port while the controller is in reset
    for (int i = 0; i < 32; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h1 : $urandom;
      pre[i]      = bus.wr_data;
      step();
    end
    bus.wr_en = 1'b0;

    // Reset state, with a request offered that must not be taken
    bus.req_vld  = 1'b1;
    bus.req_addr = 5'd3;
    @(negedge clk);
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
    chk("rst_arr_rden", 64'(bus.arr_rden), 64'(0));
    chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    step();
    bus.req_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_rdy", 64'(bus.req_rdy), 64'(1));
    step();

    // Basic read with latency
    bus.rsp_rdy = 1'b1;
    do_req(5'd5, 1'b0, 5'd0, 32'h0, rden);
    chk("basic_rden", 64'(rden), 64'(1));
    expect_rsp("basic", 32'hDEADBEEF, 1'b0, lat);
    chk("basic_latency", 64'(lat), 64'(1));

    // Same-cycle write to the requested entry
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_RD_BYPASS_EN
    byp_exp = 32'h22;
`else
    byp_exp = 32'h1;
`endif
    do_req(5'd7, 1'b1, 5'd7, 32'h22, rden);
    expect_rsp("bypass", byp_exp, 1'b0, lat);

    // Write one cycle after the accept is not forwarded
    do_req(5'd7, 1'b0, 5'd0, 32'h0, rden);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'h33;
    expect_rsp("late_write", 32'h22, 1'b0, lat);
    bus.wr_en = 1'b0;

    // Out-of-range addresses, back to back
    do_req(5'd28, 1'b0, 5'd0, 32'h0, rden);
    chk("oor28_rden", 64'(rden), 64'(0));
    do_req(5'd31, 1'b0, 5'd0, 32'h0, rden);
    chk("oor31_rden", 64'(rden), 64'(0));
    expect_rsp("oor28", 32'h0, 1'b1, lat);
    expect_rsp("oor31", 32'h0, 1'b1, lat);

    // Backpressure: three accepted, fourth held off
    step();
    bus.rsp_rdy = 1'b0;
    do_req(5'd1, 1'b0, 5'd0, 32'h0, rden);
    do_req(5'd2, 1'b0, 5'd0, 32'h0, rden);
    do_req(5'd3, 1'b0, 5'd0, 32'h0, rden);
    bus.req_vld  = 1'b1;
    bus.req_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_req_rdy_low", 64'(bus.req_rdy), 64'(0));
      step();
    end
    base = log_q.size();
    bus.rsp_rdy = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_reassert", 64'(n), 64'(1));
    step();
    bus.req_vld = 1'b0;
    repeat (6) step();
    chk("bp_count", 64'(log_q.size() - base), 64'(4));
    if (log_q.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bp_data", 64'(log_q[base+i].data), 64'(pre[i+1]));
        chk("bp_gapless", 64'(log_q[base+i].edge_i), 64'(log_q[base].edge_i + i));
      end
    end

    // Streaming: 20 back-to-back requests
    base = log_q.size();
    for (int i = 0; i < 20; i++) begin
      bus.req_vld  = 1'b1;
      bus.req_addr = AW'(i);
      @(negedge clk);
      chk("stream_req_rdy", 64'(bus.req_rdy), 64'(1));
      step();
    end
    bus.req_vld = 1'b0;
    repeat (5) step();
    chk("stream_count", 64'(log_q.size() - base), 64'(20));
    if (log_q.size() - base >= 20) begin
      for (int i = 0; i < 20; i++)
        chk("stream_gapless", 64'(log_q[base+i].edge_i), 64'(log_q[base].edge_i + i));
    end

    // Reset with one request in flight and two queued
    bus.rsp_rdy = 1'b0;
    do_req(5'd10, 1'b0, 5'd0, 32'h0, rden);
    do_req(5'd11, 1'b0, 5'd0, 32'h0, rden);
    do_req(5'd12, 1'b0, 5'd0, 32'h0, rden);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_rsp_vld", 64'(bus.rsp_vld), 64'(0));
    step();
    rst = 1'b1;
    base = log_q.size();
    bus.rsp_rdy = 1'b1;
    repeat (6) step();
    chk("midrst_no_stale", 64'(log_q.size() - base), 64'(0));
    do_req(5'd12, 1'b0, 5'd0, 32'h0, rden);
    expect_rsp("post_rst", pre[12], 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'(1));

    // Randomized traffic, including writes aimed at the read address
    for (int i = 0; i < 400; i++) begin
      bus.req_vld  = ($urandom_range(0, 3) != 0);
      bus.req_addr = AW'($urandom_range(0, 31));
      bus.wr_en    = ($urandom_range(0, 1) != 0);
      bus.wr_addr  = ($urandom_range(0, 2) == 0) ? bus.req_addr : AW'($urandom_range(0, 27));
      bus.wr_data  = $urandom;
      bus.rsp_rdy  = ($urandom_range(0, 2) != 0);
      rst          = ($urandom_range(0, 149) != 0);
      step();
    end

    // Drain
    rst         = 1'b1;
    bus.req_vld = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rsp_rdy = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_rsp_vld", 64'(bus.rsp_vld), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
